// File: rtl/keylock_ctrl.sv
// Digit-code door lock sequencer: entry, compare, unlock/auto-relock, lockout, reprogramming.
// Optional KEYLOCK_CTRL_ALARM_EN adds a sticky alarm output set on lockout entry.
module keylock_ctrl #(
  parameter int unsigned DIGITS         = 6,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned RELOCK_CYCLES  = 5000,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 24'h335256
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [3:0]                         key,
  input  logic                               key_valid,
  input  logic                               relock,
  input  logic                               prog_req,
  output logic                               locked,
  output logic                               lockout,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt,
  output logic                               prog_active,
`ifdef KEYLOCK_CTRL_ALARM_EN
  output logic                               alarm,
`endif
  output logic [2:0]                         state_dbg
);
  localparam int unsigned CW   = 4 * DIGITS;
  localparam int unsigned NW   = $clog2(DIGITS + 1);
  localparam int unsigned FW   = $clog2(MAX_FAILS + 1);
  localparam int unsigned TMAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_ENTRY    = 3'd0,
    S_CHECK    = 3'd1,
    S_UNLOCKED = 3'd2,
    S_PROG     = 3'd3,
    S_LOCKOUT  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   entry_q, entry_d;
  logic [CW-1:0]   code_q, code_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            locked_q, locked_d;
  logic            lockout_q, lockout_d;
  logic            prog_q, prog_d;
  logic            alarm_q, alarm_d;

  logic            is_digit, is_clear, last_digit;
  logic [CW-1:0]   shifted;

  always_comb begin
    is_digit   = key_valid && (key <= 4'd9);
    is_clear   = key_valid && (key == 4'hA);
    shifted    = CW'({entry_q, key});
    last_digit = (cnt_q == NW'(DIGITS - 1));

    state_d = state_q;
    cnt_d   = cnt_q;
    entry_d = entry_q;
    code_d  = code_q;
    fail_d  = fail_q;
    timer_d = timer_q;

    case (state_q)
      S_ENTRY: begin
        if (relock) begin
          cnt_d = '0;
        end else if (is_digit) begin
          entry_d = shifted;
          if (last_digit) begin
            cnt_d   = '0;
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (is_clear) begin
          cnt_d = '0;
        end
      end
      S_CHECK: begin
        if (entry_q == code_q) begin
          state_d = S_UNLOCKED;
          fail_d  = '0;
          timer_d = TW'(RELOCK_CYCLES);
        end else if (fail_q == FW'(MAX_FAILS - 1)) begin
          state_d = S_LOCKOUT;
          fail_d  = FW'(MAX_FAILS);
          timer_d = TW'(LOCKOUT_CYCLES);
        end else begin
          state_d = S_ENTRY;
          fail_d  = fail_q + 1'b1;
        end
      end
      S_UNLOCKED: begin
        // Timer value T means T more cycles remain in UNLOCKED.
        if (relock) begin
          state_d = S_ENTRY;
        end else if (prog_req) begin
          state_d = S_PROG;
          cnt_d   = '0;
        end else if (key_valid) begin
          timer_d = TW'(RELOCK_CYCLES);
        end else if (timer_q <= TW'(1)) begin
          state_d = S_ENTRY;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_PROG: begin
        if (relock) begin
          state_d = S_ENTRY;
          cnt_d   = '0;
        end else if (is_digit) begin
          entry_d = shifted;
          if (last_digit) begin
            cnt_d   = '0;
            code_d  = shifted;
            state_d = S_UNLOCKED;
            timer_d = TW'(RELOCK_CYCLES);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (is_clear) begin
          cnt_d   = '0;
          state_d = S_UNLOCKED;
        end
      end
      S_LOCKOUT: begin
        if (timer_q <= TW'(1)) begin
          state_d = S_ENTRY;
          fail_d  = '0;
          cnt_d   = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = S_ENTRY;
    endcase

    locked_d  = !((state_d == S_UNLOCKED) || (state_d == S_PROG));
    lockout_d = (state_d == S_LOCKOUT);
    prog_d    = (state_d == S_PROG);

    alarm_d = alarm_q;
    if (state_d == S_LOCKOUT && state_q != S_LOCKOUT) begin
      alarm_d = 1'b1;
    end else if (state_d == S_UNLOCKED && state_q == S_CHECK) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_ENTRY;
      cnt_q     <= '0;
      entry_q   <= '0;
      code_q    <= DEFAULT_CODE;
      fail_q    <= '0;
      timer_q   <= '0;
      locked_q  <= 1'b1;
      lockout_q <= 1'b0;
      prog_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      entry_q   <= entry_d;
      code_q    <= code_d;
      fail_q    <= fail_d;
      timer_q   <= timer_d;
      locked_q  <= locked_d;
      lockout_q <= lockout_d;
      prog_q    <= prog_d;
      alarm_q   <= alarm_d;
    end
  end

  assign locked      = locked_q;
  assign lockout     = lockout_q;
  assign fail_cnt    = fail_q;
  assign prog_active = prog_q;
  assign state_dbg   = state_q;
`ifdef KEYLOCK_CTRL_ALARM_EN
  assign alarm       = alarm_q;
`else
  logic unused_alarm;
  assign unused_alarm = alarm_q;
`endif

endmodule

// File: tb/tb_keylock_ctrl.sv
// Scoreboarded bench for keylock_ctrl: entry, clear/ignore keys, lockout, auto-relock, reprogram, reset.
module tb_keylock_ctrl;
  localparam int unsigned LOCK_N   = 16;
  localparam int unsigned RELOCK_N = 32;

  logic       clk;
  logic       reset_n;
  logic [3:0] key;
  logic       key_valid;
  logic       relock;
  logic       prog_req;
  logic       locked;
  logic       lockout;
  logic [1:0] fail_cnt;
  logic       prog_active;
  logic [2:0] state_dbg;
`ifdef KEYLOCK_CTRL_ALARM_EN
  logic       alarm;
`endif

  // Status word: {locked, lockout, fail_cnt[1:0], prog_active}
  logic [4:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  keylock_ctrl #(
    .LOCKOUT_CYCLES(LOCK_N),
    .RELOCK_CYCLES (RELOCK_N)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key        (key),
    .key_valid  (key_valid),
    .relock     (relock),
    .prog_req   (prog_req),
    .locked     (locked),
    .lockout    (lockout),
    .fail_cnt   (fail_cnt),
    .prog_active(prog_active),
`ifdef KEYLOCK_CTRL_ALARM_EN
    .alarm      (alarm),
`endif
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] status_now();
    return {locked, lockout, fail_cnt, prog_active};
  endfunction

  task automatic observe(input string tag);
    logic [4:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, 32'(status_now()), 32'(e));
    end
  endtask

  // Drivers: inputs change just after the falling edge, sampled on the next rising edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    key       = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key       = 4'h0;
  endtask

  task automatic pulse_relock();
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
  endtask

  task automatic pulse_prog();
    prog_req = 1'b1;
    @(negedge clk);
    prog_req = 1'b0;
  endtask

  task automatic press_code(input logic [23:0] c);
    for (int i = 0; i < 6; i++) press(c[23-4*i -: 4]);
  endtask

  // Full attempt from ENTRY: result is visible one cycle after the CHECK cycle.
  task automatic try_code(input logic [23:0] c, input logic [4:0] exp, input string tag);
    press_code(c);
    exp_q.push_back(exp);
    @(negedge clk);
    observe(tag);
  endtask

  initial begin
    reset_n   = 1'b0;
    key       = 4'h0;
    key_valid = 1'b0;
    relock    = 1'b0;
    prog_req  = 1'b0;
    idle(2);
    exp_q.push_back(5'b10000);
    observe("reset_status");
    check_eq("reset_state", 32'(state_dbg), 32'd0);
`ifdef KEYLOCK_CTRL_ALARM_EN
    check_eq("reset_alarm", 32'(alarm), 32'd0);
`endif
    reset_n = 1'b1;
    idle(1);

    // Correct default code: one CHECK cycle with the lock still closed
    press_code(24'h335256);
    check_eq("check_state", 32'(state_dbg), 32'd1);
    check_eq("check_locked", 32'(locked), 32'd1);
    exp_q.push_back(5'b00000);
    @(negedge clk);
    observe("unlock_default");
    pulse_relock();
    exp_q.push_back(5'b10000);
    observe("relock_req");

    // Clear mid-entry, then ignored key mid-entry
    press(4'h3); press(4'h3); press(4'hA);
    try_code(24'h335256, 5'b00000, "unlock_after_clear");
    pulse_relock();
    press(4'h3); press(4'h3); press(4'hB);
    press(4'h5); press(4'h2); press(4'h5); press(4'h6);
    exp_q.push_back(5'b00000);
    @(negedge clk);
    observe("unlock_ignored_key");
    pulse_relock();

    // Three failures -> lockout
    try_code(24'h111111, 5'b10010, "fail_1");
    try_code(24'h999999, 5'b10100, "fail_2");
    try_code(24'h335257, 5'b11110, "fail_3_lockout");
`ifdef KEYLOCK_CTRL_ALARM_EN
    check_eq("alarm_on_lockout", 32'(alarm), 32'd1);
`endif
    // 1 lockout cycle elapsed; the code below consumes 6 more
    press_code(24'h335256);
    exp_q.push_back(5'b11110);
    observe("lockout_ignores_code");
    idle(LOCK_N - 7);
    check_eq("lockout_last_cycle", 32'(lockout), 32'd1);
    idle(1);
    exp_q.push_back(5'b10000);
    observe("lockout_exit");
`ifdef KEYLOCK_CTRL_ALARM_EN
    check_eq("alarm_sticky", 32'(alarm), 32'd1);
`endif
    try_code(24'h335256, 5'b00000, "unlock_after_lockout");
`ifdef KEYLOCK_CTRL_ALARM_EN
    check_eq("alarm_cleared", 32'(alarm), 32'd0);
`endif

    // Auto-relock after RELOCK_N idle cycles
    idle(RELOCK_N - 1);
    check_eq("relock_edge_open", 32'(locked), 32'd0);
    idle(1);
    exp_q.push_back(5'b10000);
    observe("auto_relock");

    // Key at cycle 20 reloads the timer
    try_code(24'h335256, 5'b00000, "unlock_for_reload");
    idle(19);
    press(4'h7);
    idle(RELOCK_N - 1);
    check_eq("reload_still_open", 32'(locked), 32'd0);
    idle(1);
    check_eq("reload_relock", 32'(locked), 32'd1);

    // Reprogram to 123456
    try_code(24'h335256, 5'b00000, "unlock_for_prog");
    pulse_prog();
    exp_q.push_back(5'b00001);
    observe("prog_enter");
    press_code(24'h123456);
    exp_q.push_back(5'b00000);
    observe("prog_done");
    check_eq("prog_state_unlocked", 32'(state_dbg), 32'd2);
    pulse_relock();
    exp_q.push_back(5'b10000);
    observe("relock_after_prog");
    try_code(24'h335256, 5'b10010, "old_code_rejected");
    try_code(24'h123456, 5'b00000, "new_code_accepted");

    // relock beats prog_req
    relock   = 1'b1;
    prog_req = 1'b1;
    @(negedge clk);
    relock   = 1'b0;
    prog_req = 1'b0;
    exp_q.push_back(5'b10000);
    observe("relock_over_prog");
    check_eq("relock_over_prog_state", 32'(state_dbg), 32'd0);

    // Asynchronous reset mid-PROG restores the default code
    try_code(24'h123456, 5'b00000, "unlock_before_reset");
    pulse_prog();
    press(4'h9); press(4'h9);
    #2 reset_n = 1'b0;
    #1;
    exp_q.push_back(5'b10000);
    observe("reset_mid_prog");
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    try_code(24'h123456, 5'b10010, "prog_code_gone");
    try_code(24'h335256, 5'b00000, "default_restored");

    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
